// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the fetch/decode pipeline stage FIFO.
//   - NOP_OPCODE / NOP_INSTR_32 : bubble encoding shown on an empty stage
//   - MIPS field bit positions and widths used by the optional decode slices
//   - pipe_entry_t              : {instr, pc} entry for the 32/32 configuration
package pipe_pkg;

  localparam logic [5:0]  NOP_OPCODE   = 6'b111000;
  localparam logic [31:0] NOP_INSTR_32 = {NOP_OPCODE, 26'd0};

  // MIPS instruction field layout (LSB position, width)
  localparam int OPCODE_LSB  = 26;
  localparam int OPCODE_W    = 6;
  localparam int RS_LSB      = 21;
  localparam int RT_LSB      = 16;
  localparam int RD_LSB      = 11;
  localparam int SHAMT_LSB   = 6;
  localparam int REG_W       = 5;
  localparam int FUNCT_LSB   = 0;
  localparam int FUNCT_W     = 6;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 16;
  localparam int JTARGET_LSB = 0;
  localparam int JTARGET_W   = 26;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_fifo_mem.sv
// pipe_fifo_mem: DEPTH x W storage with one write port and one registered
// read port.
//   clk, reset        : clock, asynchronous active-low reset (read register only)
//   wr_en/addr/data   : write port, written on the rising edge
//   rd_en/addr        : read request; rd_data updates on the next edge
//   rd_data           : registered read data, holds when rd_en=0
// The array itself is not reset. A write and read of the same address in one
// cycle returns the new data, so an entry written into an empty queue is
// visible as the head on the following cycle.
module pipe_fifo_mem #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: elastic fetch->decode pipeline stage (DEPTH=2 is a skid
// buffer). Holds {instr, pc+4} entries in strict FIFO order.
//   clk, reset            : clock, asynchronous active-low reset
//   flush                 : synchronous kill of all entries (mispredict)
//   in_valid/in_ready     : upstream handshake, in_instr/in_pc payload
//   out_valid/out_ready   : downstream handshake, out_instr/out_pc payload
//   count                 : number of occupied entries
// Optional macro PIPE_STAGE_DECODE_EN adds MIPS field outputs (out_opcode,
// out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm, out_jtarget).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high at that side; ready never depends on the same side's valid, and
// in_ready never depends on out_ready (it is a function of registered count,
// flush and reset only). An accepted entry reaches out_* one cycle after the
// push edge at the earliest.
module pipe_stage_fifo
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter int                 DEPTH     = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_32)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [PC_W-1:0]          out_pc,
`ifdef PIPE_STAGE_DECODE_EN
  output logic [5:0]               out_opcode,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_shamt,
  output logic [5:0]               out_funct,
  output logic [15:0]              out_imm,
  output logic [25:0]              out_jtarget,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = INSTR_W + PC_W;

  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr_nxt;
  logic [CW-1:0]      count_nxt;
  logic               push;
  logic               pop;
  logic               rd_en;
  logic [EW-1:0]      head;
  logic [INSTR_W-1:0] head_instr;

  // reset gates in_ready so nothing is offered as accepted while held in reset
  assign in_ready  = reset && !flush && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (pop) rd_ptr_nxt = rd_ptr + 1'b1;
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Refresh the head register whenever the stage will be non-empty after this
  // edge; the read address is the post-pop pointer so the new head is ready
  // on the following cycle. When empty (or flushed) the register holds, which
  // keeps out_pc at its last value and never exposes an unoccupied slot.
  assign rd_en = !flush && (count_nxt != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  pipe_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({in_instr, in_pc}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_nxt),
    .rd_data (head)
  );

  assign head_instr = head[EW-1:PC_W];
  assign out_instr  = out_valid ? head_instr : NOP_INSTR;
  assign out_pc     = head[PC_W-1:0];

`ifdef PIPE_STAGE_DECODE_EN
  // Fields are slices of the registered head entry, so they change on the
  // same edge as out_instr; an empty stage shows the bubble opcode and zeros.
  assign out_opcode  = out_valid ? head_instr[OPCODE_LSB +: OPCODE_W]   : NOP_OPCODE;
  assign out_rs      = out_valid ? head_instr[RS_LSB +: REG_W]          : '0;
  assign out_rt      = out_valid ? head_instr[RT_LSB +: REG_W]          : '0;
  assign out_rd      = out_valid ? head_instr[RD_LSB +: REG_W]          : '0;
  assign out_shamt   = out_valid ? head_instr[SHAMT_LSB +: REG_W]       : '0;
  assign out_funct   = out_valid ? head_instr[FUNCT_LSB +: FUNCT_W]     : '0;
  assign out_imm     = out_valid ? head_instr[IMM_LSB +: IMM_W]         : '0;
  assign out_jtarget = out_valid ? head_instr[JTARGET_LSB +: JTARGET_W] : '0;
`endif

endmodule

// File: doc/pipe_stage_fifo.md
PIPE_STAGE_FIFO -- requirements
Module: pipe_stage_fifo

Interface
REQ-001 Parameter INSTR_W, default 32: instruction payload width in bits.
REQ-002 Parameter PC_W, default 32: PC+4 payload width in bits.
REQ-003 Parameter DEPTH, default 2: entry count; power of two, 2..16 (2 = skid buffer).
REQ-004 Parameter NOP_INSTR, default 32'hE000_0000: bubble encoding, opcode 6'b111000.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous kill of all held entries (branch mispredict).
REQ-008 in_valid  input  1  upstream (fetch) offers an entry.
REQ-009 in_ready  output  1  stage accepts an entry this cycle.
REQ-010 in_instr  input  INSTR_W  fetched instruction.
REQ-011 in_pc  input  PC_W  PC+4 of the fetched instruction.
REQ-012 out_valid  output  1  head entry is valid for decode.
REQ-013 out_ready  input  1  downstream (decode/hazard unit) consumes the head this cycle.
REQ-014 out_instr  output  INSTR_W  head instruction, or NOP_INSTR when out_valid=0.
REQ-015 out_pc  output  PC_W  head PC+4; holds its last value when out_valid=0.
REQ-016 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 in_ready = (count < DEPTH) && !flush; no combinational path from out_ready to in_ready.
REQ-019 Latency: a pushed entry appears at out_* on the cycle after the push edge, at the earliest; no same-cycle bypass.
REQ-020 Order is strictly FIFO; payloads are stored and emitted unmodified.
REQ-021 Simultaneous push and pop with 0 < count < DEPTH: count unchanged; head advances; tail written.
REQ-022 count = DEPTH: in_ready=0; a pop frees one entry, visible as in_ready=1 on the next cycle.
REQ-023 count = 0: out_valid=0, out_instr=NOP_INSTR; out_ready is ignored.
REQ-024 Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no gap.
REQ-025 flush=1: on the next edge count=0, out_valid=0, and pointers reset; any push offered in that cycle is dropped; flush takes priority over push and pop.
REQ-026 in_valid while stalled (in_ready=0) leaves state unchanged; upstream holds its payload.

Reset
REQ-027 While reset=0: count=0, pointers=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=0.
REQ-028 Reset asserted mid-operation discards all entries immediately (asynchronous); the first push is accepted on the first edge after release.
REQ-029 Storage array contents are not reset; no output depends on an unoccupied entry.

Configuration
REQ-030 Macro PIPE_STAGE_DECODE_EN: when defined, the block adds registered outputs out_opcode[5:0], out_rs[4:0], out_rt[4:0], out_rd[4:0], out_shamt[4:0], out_funct[5:0], out_imm[15:0], and out_jtarget[25:0], sliced from the head instruction (bits 31:26, 25:21, 20:16, 15:11, 10:6, 5:0, 15:0, 25:0).
REQ-031 With PIPE_STAGE_DECODE_EN defined and out_valid=0: out_opcode=6'b111000 and every other field=0 (never X); field updates occur on the same cycle as out_instr.
REQ-032 Without PIPE_STAGE_DECODE_EN: the field ports do not exist and there are no decode registers.

Structure
REQ-033 Shared package pipe_pkg holds NOP_OPCODE, NOP_INSTR_32, MIPS field bit-position/width localparams, and a typedef for the {instr, pc} entry struct.
REQ-034 Storage is one sub-module, pipe_fifo_mem: DEPTH x (INSTR_W+PC_W) array, one write port, one registered read port; control (pointers, count, flush) stays in pipe_stage_fifo.

Verification
REQ-035 Reset release, then push instr 32'h2108_0004 / pc 32'h4 -> out_valid=1 one cycle later, out_instr=32'h2108_0004, count=1.
REQ-036 DEPTH=2, out_ready=0, push three entries -> third is refused (in_ready=0), count=2; one pop -> in_ready=1 next cycle, third entry accepted.
REQ-037 count=1, flush=1 together with in_valid=1 -> next cycle count=0, out_instr=32'hE000_0000, pushed entry never emitted.
REQ-038 DEPTH=4, continuous push/pop for 10 entries with random out_ready -> output sequence equals input sequence, pointers wrap, and count never exceeds 4.
REQ-039 Assert reset with count=2 between edges -> outputs go to reset values without waiting for clk; after release, count=0.
REQ-040 PIPE_STAGE_DECODE_EN defined, push 32'h0128_5020 -> out_rs=9, out_rt=8, out_rd=10, out_funct=6'h20; when empty, out_opcode=6'b111000.
